game_period: RTL and testbench
==============================

// Module: game_period
// PURPOSE
//  Downstream of the preliminary countdown: on the one-cycle gameSig start strobe, runs one timed guessing round.
//  Player steps a guess with up/down buttons and submits; round ends on submit or timeout. Guess is compared to
//  targetCount, then a win/lose result plus next level go to the level controller, and seg0..seg3 are driven.
// PARAMETERS
//  BASE_TIME    30  round length in seconds at level 0
//  TIME_STEP    2   seconds removed per level
//  MIN_TIME     8   floor on round length (seconds)
//  MAX_LEVEL    9   highest level; nextLevel saturates here
//  RESULT_SECS  3   seconds the result screen is held before roundDone
// PORTS
//  Clk100M      in   1  system clock, all logic on rising edge
//  Reset_n      in   1  asynchronous, active-low reset
//  Clk1Hz       in   1  1 Hz square wave, not a clock here; 2-FF synchronised, rising edge = 1 s tick
//  gameSig      in   1  start-round strobe (level-sampled; only acted on in IDLE)
//  curLevel     in   4  current level, sampled when round starts
//  targetCount  in   8  correct answer (0..99), sampled when round starts
//  btnUp        in   1  debounced 1-cycle pulse: guess +1
//  btnDown      in   1  debounced 1-cycle pulse: guess -1
//  btnSubmit    in   1  debounced 1-cycle pulse: submit guess
//  roundDone    out  1  1-cycle pulse when result hold ends
//  roundWin     out  1  result of last round; valid from CHECK exit, held until next start
//  nextLevel    out  4  level for next round; valid with roundWin
//  seg0..seg3   out  8  active-low segments {dp,g..a}; 8'hFF = blank
// BEHAVIOUR
//  Reset: state=IDLE, roundDone=0, roundWin=0, nextLevel=0, guess=0, timeLeft=0, all seg=8'hFF.
//  Tick: tick=1 for exactly one Clk100M cycle per synchronised Clk1Hz rising edge (latency 3 cycles).
//  FSM states IDLE, PLAY, CHECK, RESULT:
//   IDLE:   seg all 8'hFF. gameSig=1 -> PLAY next cycle; latch lvl=curLevel, tgt=targetCount, guess=0,
//           timeLeft=max(BASE_TIME-lvl*TIME_STEP, MIN_TIME) (compute in 8 bits, no underflow: compare first).
//   PLAY:   tick -> timeLeft-1. btnUp -> guess+1 saturating at 99; btnDown -> guess-1 saturating at 0;
//           btnUp&btnDown same cycle -> no change. btnSubmit, or tick when timeLeft==1 -> CHECK.
//           Submit and final tick same cycle: submit wins (guess counts). Buttons in the exit cycle are ignored.
//           gameSig in PLAY/CHECK/RESULT ignored (no restart).
//   CHECK:  one cycle. roundWin=(guess==tgt) AND not timed out; nextLevel=win ? min(lvl+1,MAX_LEVEL) : lvl.
//           Registered on CHECK->RESULT edge. Load holdCnt=RESULT_SECS.
//   RESULT: tick -> holdCnt-1; when holdCnt reaches 0 -> roundDone=1 for one cycle, state IDLE.
//  Display (registered, 1-cycle after state/value change):
//   PLAY:   seg3,seg2 = timeLeft tens,units; seg1,seg0 = guess tens,units; leading zero on tens shown.
//   CHECK/RESULT: win -> seg3..0 = "PASS"; lose -> "FAIL"; decimal points off.
//  Timeout when targetCount>99: guess can never match -> loss (no error flag).
//  Reset_n low mid-round: immediate return to reset values; no roundDone pulse generated.
// TESTING
//  Lvl 0, tgt 5: gameSig, 5x btnUp, submit at t=10 s -> roundWin=1, nextLevel=1, "PASS", roundDone 3 s later.
//  Lvl 2, tgt 7: gameSig, no input -> timeLeft starts 26, reaches 0 after 26 ticks, roundWin=0, nextLevel=2.
//  Lvl 12 / lvl 9 win: timeLeft=MIN_TIME (8); lvl 9 win -> nextLevel=9 (saturation).
//  Guess clamp: 3x btnDown from 0 -> guess 0; 105x btnUp -> guess 99; btnUp+btnDown same cycle -> unchanged.
//  Submit coincident with final tick, guess==tgt -> roundWin=1; gameSig pulsed during PLAY -> no restart.
//  Reset_n asserted in PLAY and RESULT -> all outputs to reset values same edge, no roundDone pulse.

Source files
------------

// File: rtl/game_period_if.sv
// Handshake/bus bundle between the round controller and its surroundings.
interface game_period_if;
    logic       gameSig;
    logic [3:0] curLevel;
    logic [7:0] targetCount;
    logic       btnUp;
    logic       btnDown;
    logic       btnSubmit;
    logic       roundDone;
    logic       roundWin;
    logic [3:0] nextLevel;
    logic [7:0] seg0;
    logic [7:0] seg1;
    logic [7:0] seg2;
    logic [7:0] seg3;

    modport master (
        output gameSig, curLevel, targetCount,
        output btnUp, btnDown, btnSubmit,
        input  roundDone, roundWin, nextLevel,
        input  seg0, seg1, seg2, seg3
    );

    modport slave (
        input  gameSig, curLevel, targetCount,
        input  btnUp, btnDown, btnSubmit,
        output roundDone, roundWin, nextLevel,
        output seg0, seg1, seg2, seg3
    );
endinterface

// File: rtl/game_period.sv
// One timed guessing round: step a guess, submit or time out, show PASS/FAIL,
// then report result and next level to the level controller.
module game_period #(
    parameter int BASE_TIME   = 30,
    parameter int TIME_STEP   = 2,
    parameter int MIN_TIME    = 8,
    parameter int MAX_LEVEL   = 9,
    parameter int RESULT_SECS = 3
) (
    input  logic Clk100M,
    input  logic Reset_n,
    input  logic Clk1Hz,
    game_period_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PLAY, CHECK, RESULT} state_t;

    localparam logic [7:0] BT = 8'(BASE_TIME);
    localparam logic [7:0] TS = 8'(TIME_STEP);
    localparam logic [7:0] MT = 8'(MIN_TIME);
    localparam logic [3:0] ML = 4'(MAX_LEVEL);
    localparam logic [7:0] RS = 8'(RESULT_SECS);

    state_t     state;
    logic [2:0] sync;
    logic       tick;
    logic [3:0] lvl;
    logic [7:0] tgt;
    logic [6:0] guess;
    logic [7:0] timeLeft;
    logic [7:0] holdCnt;
    logic       timedOut;

    logic [7:0] dec;
    logic [7:0] startTime;
    logic       winC;

    // Compare before subtracting so high levels cannot wrap below the floor.
    always_comb begin
        dec       = 8'(bus.curLevel) * TS;
        startTime = MT;
        if (BT > dec && (BT - dec) > MT)
            startTime = BT - dec;
    end

    assign winC = ({1'b0, guess} == tgt) && !timedOut;

    always_ff @(posedge Clk100M or negedge Reset_n) begin
        if (!Reset_n) begin
            sync <= '0;
            tick <= 1'b0;
        end else begin
            sync <= {sync[1:0], Clk1Hz};
            tick <= sync[1] & ~sync[2];
        end
    end

    always_ff @(posedge Clk100M or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= IDLE;
            lvl           <= '0;
            tgt           <= '0;
            guess         <= '0;
            timeLeft      <= '0;
            holdCnt       <= '0;
            timedOut      <= 1'b0;
            bus.roundDone <= 1'b0;
            bus.roundWin  <= 1'b0;
            bus.nextLevel <= '0;
        end else begin
            bus.roundDone <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.gameSig) begin
                        state    <= PLAY;
                        lvl      <= bus.curLevel;
                        tgt      <= bus.targetCount;
                        guess    <= '0;
                        timeLeft <= startTime;
                    end
                end
                PLAY: begin
                    if (tick && timeLeft != 8'd0)
                        timeLeft <= timeLeft - 8'd1;
                    if (bus.btnSubmit || (tick && timeLeft == 8'd1)) begin
                        state    <= CHECK;
                        timedOut <= !bus.btnSubmit;
                    end else if (bus.btnUp && !bus.btnDown) begin
                        if (guess != 7'd99)
                            guess <= guess + 7'd1;
                    end else if (bus.btnDown && !bus.btnUp) begin
                        if (guess != 7'd0)
                            guess <= guess - 7'd1;
                    end
                end
                CHECK: begin
                    state        <= RESULT;
                    holdCnt      <= RS;
                    bus.roundWin <= winC;
                    if (!winC)
                        bus.nextLevel <= lvl;
                    else if (lvl >= ML)
                        bus.nextLevel <= ML;
                    else
                        bus.nextLevel <= lvl + 4'd1;
                end
                RESULT: begin
                    if (tick) begin
                        holdCnt <= holdCnt - 8'd1;
                        if (holdCnt <= 8'd1) begin
                            bus.roundDone <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    function automatic logic [7:0] digit(input logic [7:0] d);
        case (d)
            8'd0:    digit = 8'hC0;
            8'd1:    digit = 8'hF9;
            8'd2:    digit = 8'hA4;
            8'd3:    digit = 8'hB0;
            8'd4:    digit = 8'h99;
            8'd5:    digit = 8'h92;
            8'd6:    digit = 8'h82;
            8'd7:    digit = 8'hF8;
            8'd8:    digit = 8'h80;
            8'd9:    digit = 8'h90;
            default: digit = 8'hFF;
        endcase
    endfunction

    logic [7:0] gw;
    assign gw = {1'b0, guess};

    // In CHECK the result is not registered yet, so both screens use winC.
    always_ff @(posedge Clk100M or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.seg3 <= 8'hFF;
            bus.seg2 <= 8'hFF;
            bus.seg1 <= 8'hFF;
            bus.seg0 <= 8'hFF;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.seg3 <= 8'hFF;
                    bus.seg2 <= 8'hFF;
                    bus.seg1 <= 8'hFF;
                    bus.seg0 <= 8'hFF;
                end
                PLAY: begin
                    bus.seg3 <= digit(timeLeft / 8'd10);
                    bus.seg2 <= digit(timeLeft % 8'd10);
                    bus.seg1 <= digit(gw / 8'd10);
                    bus.seg0 <= digit(gw % 8'd10);
                end
                CHECK, RESULT: begin
                    if (winC) begin
                        bus.seg3 <= 8'h8C;
                        bus.seg2 <= 8'h88;
                        bus.seg1 <= 8'h92;
                        bus.seg0 <= 8'h92;
                    end else begin
                        bus.seg3 <= 8'h8E;
                        bus.seg2 <= 8'h88;
                        bus.seg1 <= 8'hF9;
                        bus.seg0 <= 8'hC7;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_game_period.sv
// Directed bench for game_period: rounds at several levels, clamps,
// coincident submit/timeout, restart immunity and mid-round reset.
module tb_game_period;
    logic Clk100M = 1'b0;
    logic Reset_n = 1'b0;
    logic Clk1Hz  = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   doneCnt = 0;

    localparam logic [31:0] BLANK = 32'hFFFF_FFFF;
    localparam logic [31:0] PASS  = 32'h8C88_9292;
    localparam logic [31:0] LOSE  = 32'h8E88_F9C7;

    game_period_if ifc();

    game_period dut (
        .Clk100M (Clk100M),
        .Reset_n (Reset_n),
        .Clk1Hz  (Clk1Hz),
        .bus     (ifc)
    );

    always #5 Clk100M = ~Clk100M;

    always @(negedge Clk100M)
        if (ifc.roundDone) doneCnt++;

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk100M);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] segs();
        return {ifc.seg3, ifc.seg2, ifc.seg1, ifc.seg0};
    endfunction

    task automatic sec(input int n);
        repeat (n) begin
            Clk1Hz = 1'b1;
            cyc(4);
            Clk1Hz = 1'b0;
            cyc(4);
        end
    endtask

    task automatic press(input logic u, input logic d, input logic s);
        @(negedge Clk100M);
        ifc.btnUp     = u;
        ifc.btnDown   = d;
        ifc.btnSubmit = s;
        @(negedge Clk100M);
        ifc.btnUp     = 1'b0;
        ifc.btnDown   = 1'b0;
        ifc.btnSubmit = 1'b0;
    endtask

    task automatic start(input logic [3:0] l, input logic [7:0] t);
        ifc.curLevel    = l;
        ifc.targetCount = t;
        @(negedge Clk100M);
        ifc.gameSig = 1'b1;
        @(negedge Clk100M);
        ifc.gameSig = 1'b0;
        cyc(2);
    endtask

    initial begin
        ifc.gameSig     = 1'b0;
        ifc.curLevel    = '0;
        ifc.targetCount = '0;
        ifc.btnUp       = 1'b0;
        ifc.btnDown     = 1'b0;
        ifc.btnSubmit   = 1'b0;
        cyc(3);
        chk("rst_seg", segs(), BLANK);
        chk("rst_win", 32'(ifc.roundWin), 32'd0);
        chk("rst_lvl", 32'(ifc.nextLevel), 32'd0);
        Reset_n = 1'b1;
        cyc(2);

        // Level 0, target 5: five ups, submit with 20 s left
        start(4'd0, 8'd5);
        chk("l0_start", segs(), 32'hB0C0_C0C0);
        repeat (5) press(1'b1, 1'b0, 1'b0);
        cyc(2);
        chk("l0_guess5", segs(), 32'hB0C0_C092);
        sec(10);
        chk("l0_t20", segs(), 32'hA4C0_C092);
        press(1'b0, 1'b0, 1'b1);
        cyc(3);
        chk("l0_pass", segs(), PASS);
        chk("l0_win", 32'(ifc.roundWin), 32'd1);
        chk("l0_next", 32'(ifc.nextLevel), 32'd1);
        sec(2);
        chk("l0_hold", 32'(doneCnt), 32'd0);
        sec(1);
        chk("l0_done", 32'(doneCnt), 32'd1);
        chk("l0_idle", segs(), BLANK);

        // Level 2, target 7: no input, runs out after 26 ticks
        start(4'd2, 8'd7);
        chk("l2_start", segs(), 32'hA482_C0C0);
        sec(25);
        chk("l2_t1", segs(), 32'hC0F9_C0C0);
        sec(1);
        chk("l2_fail", segs(), LOSE);
        chk("l2_win", 32'(ifc.roundWin), 32'd0);
        chk("l2_next", 32'(ifc.nextLevel), 32'd2);
        sec(3);
        chk("l2_done", 32'(doneCnt), 32'd2);

        // Level 12: time floor, down clamp at 0, win saturates level
        start(4'd12, 8'd0);
        chk("l12_start", segs(), 32'hC080_C0C0);
        repeat (3) press(1'b0, 1'b1, 1'b0);
        cyc(2);
        chk("l12_clamp0", segs(), 32'hC080_C0C0);
        press(1'b0, 1'b0, 1'b1);
        cyc(3);
        chk("l12_win", 32'(ifc.roundWin), 32'd1);
        chk("l12_next", 32'(ifc.nextLevel), 32'd9);
        sec(3);
        chk("l12_done", 32'(doneCnt), 32'd3);

        // Level 9, target 99: clamp high, both buttons, no restart,
        // submit on the same cycle as the final tick
        start(4'd9, 8'd99);
        chk("l9_start", segs(), 32'hF9A4_C0C0);
        repeat (105) press(1'b1, 1'b0, 1'b0);
        cyc(2);
        chk("l9_clamp99", segs(), 32'hF9A4_9090);
        press(1'b1, 1'b1, 1'b0);
        cyc(2);
        chk("l9_both", segs(), 32'hF9A4_9090);
        sec(1);
        @(negedge Clk100M);
        ifc.gameSig = 1'b1;
        @(negedge Clk100M);
        ifc.gameSig = 1'b0;
        cyc(2);
        chk("l9_norestart", segs(), 32'hF9F9_9090);
        sec(10);
        chk("l9_t1", segs(), 32'hC0F9_9090);
        Clk1Hz = 1'b1;
        cyc(3);
        ifc.btnSubmit = 1'b1;
        cyc(1);
        ifc.btnSubmit = 1'b0;
        Clk1Hz = 1'b0;
        cyc(4);
        chk("l9_pass", segs(), PASS);
        chk("l9_win", 32'(ifc.roundWin), 32'd1);
        chk("l9_next", 32'(ifc.nextLevel), 32'd9);
        sec(3);
        chk("l9_done", 32'(doneCnt), 32'd4);

        // Reset during PLAY
        start(4'd0, 8'd5);
        press(1'b1, 1'b0, 1'b0);
        cyc(2);
        chk("rp_play", segs(), 32'hB0C0_C0F9);
        @(negedge Clk100M);
        Reset_n = 1'b0;
        #1;
        chk("rp_seg", segs(), BLANK);
        chk("rp_win", 32'(ifc.roundWin), 32'd0);
        chk("rp_next", 32'(ifc.nextLevel), 32'd0);
        @(negedge Clk100M);
        Reset_n = 1'b1;
        sec(2);
        chk("rp_idle", segs(), BLANK);

        // Reset during RESULT
        start(4'd3, 8'd0);
        press(1'b0, 1'b0, 1'b1);
        cyc(3);
        chk("rr_win", 32'(ifc.roundWin), 32'd1);
        chk("rr_next", 32'(ifc.nextLevel), 32'd4);
        @(negedge Clk100M);
        Reset_n = 1'b0;
        #1;
        chk("rr_seg", segs(), BLANK);
        chk("rr_win0", 32'(ifc.roundWin), 32'd0);
        chk("rr_next0", 32'(ifc.nextLevel), 32'd0);
        @(negedge Clk100M);
        Reset_n = 1'b1;
        sec(4);
        chk("rr_nodone", 32'(doneCnt), 32'd4);
        chk("rr_idle", segs(), BLANK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
